// File: rtl/i2c_arb_if.sv
// Requester-side bus of the I2C bus arbiter: descriptors and requests in,
// grant / byte strobe / read data / completion status out.
interface i2c_arb_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0]    req;
   logic [7*N_REQ-1:0]  req_addr;
   logic [16*N_REQ-1:0] req_reg;
   logic [N_REQ-1:0]    req_rd;
   logic [17*N_REQ-1:0] req_len;
   logic [8*N_REQ-1:0]  req_wdata;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    byte_stb;
   logic [7:0]          rd_data;
   logic [N_REQ-1:0]    done;
   logic [N_REQ-1:0]    err;

   // Requester side: drives requests and descriptors, observes status.
   modport master (
      output req, req_addr, req_reg, req_rd, req_len, req_wdata,
      input  gnt, byte_stb, rd_data, done, err
   );

   // Arbiter side: samples requests and descriptors, drives status.
   modport slave (
      input  req, req_addr, req_reg, req_rd, req_len, req_wdata,
      output gnt, byte_stb, rd_data, done, err
   );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one I2C master engine
// among N_REQ requesters. Optional transfer watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned STOP_GUARD = 64,
   parameter int unsigned TIMEOUT    = 200000
) (
   input  logic        clock,
   input  logic        reset,
   i2c_arb_if.slave    bus,
   output logic        eng_start,
   output logic        eng_reset,
   output logic [6:0]  eng_addr,
   output logic [15:0] eng_reg,
   output logic        eng_rd,
   output logic [16:0] eng_len,
   output logic [7:0]  eng_wdata,
   input  logic        eng_ready,
   input  logic [7:0]  eng_rdata
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned PTR_W = IDX_W + 1;
   // One counter serves both the stop guard and the watchdog (never active together).
   localparam int unsigned SPAN  = (STOP_GUARD > TIMEOUT) ? STOP_GUARD : TIMEOUT;
   localparam int unsigned CNT_W = $clog2(SPAN + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      XFER  = 3'd3,
      GUARD = 3'd4,
      DONE  = 3'd5,
      ABORT = 3'd6
   } state_t;

   state_t             state_q,  state_nxt;
   logic [IDX_W-1:0]   sel_q,    sel_nxt;
   logic [IDX_W-1:0]   rr_q,     rr_nxt;
   logic [N_REQ-1:0]   gnt_q,    gnt_nxt;
   logic [N_REQ-1:0]   stb_q,    stb_nxt;
   logic [N_REQ-1:0]   done_q,   done_nxt;
   logic [7:0]         rdata_q,  rdata_nxt;
   logic               start_q,  start_nxt;
   logic [6:0]         addr_q,   addr_nxt;
   logic [15:0]        reg_q,    reg_nxt;
   logic               rd_q,     rd_nxt;
   logic [16:0]        rem_q,    rem_nxt;
   logic [CNT_W-1:0]   cnt_q,    cnt_nxt;
   logic               ready_q;
`ifdef I2C_ARB_TIMEOUT_EN
   logic [N_REQ-1:0]   err_q,    err_nxt;
`endif

   logic               found;
   logic [IDX_W-1:0]   pick;
   logic [PTR_W-1:0]   cand;
   logic [6:0]         sel_addr;
   logic [15:0]        sel_reg;
   logic               sel_rd;
   logic [16:0]        sel_len;
   logic               rise;

   assign rise = eng_ready & ~ready_q;

   // Round-robin search: first requesting index at or after rr_q, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = PTR_W'(rr_q) + PTR_W'(i);
         if (cand >= PTR_W'(N_REQ)) cand = cand - PTR_W'(N_REQ);
         if (!found && bus.req[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[IDX_W-1:0];
         end
      end
   end

   // Descriptor fields of the selected requester.
   always_comb begin
      sel_addr = '0;
      sel_reg  = '0;
      sel_rd   = 1'b0;
      sel_len  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_q == IDX_W'(i)) begin
            sel_addr = bus.req_addr[i*7 +: 7];
            sel_reg  = bus.req_reg[i*16 +: 16];
            sel_rd   = bus.req_rd[i];
            sel_len  = bus.req_len[i*17 +: 17];
         end
      end
   end

   // Write byte follows the grant so the requester can update it per byte.
   always_comb begin
      eng_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_q[i]) eng_wdata = eng_wdata | bus.req_wdata[i*8 +: 8];
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state_q;
      sel_nxt   = sel_q;
      rr_nxt    = rr_q;
      gnt_nxt   = gnt_q;
      stb_nxt   = '0;
      done_nxt  = '0;
      rdata_nxt = rdata_q;
      start_nxt = 1'b0;
      addr_nxt  = addr_q;
      reg_nxt   = reg_q;
      rd_nxt    = rd_q;
      rem_nxt   = rem_q;
      cnt_nxt   = cnt_q;
`ifdef I2C_ARB_TIMEOUT_EN
      err_nxt   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_nxt   = pick;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            gnt_nxt   = N_REQ'(1) << sel_q;
            addr_nxt  = sel_addr;
            reg_nxt   = sel_reg;
            rd_nxt    = sel_rd;
            rem_nxt   = sel_len;
            rr_nxt    = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
            state_nxt = START;
         end
         START: begin
            start_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = XFER;
         end
         XFER: begin
            if (rise) begin
               stb_nxt = gnt_q;
               cnt_nxt = '0;
               if (rd_q) rdata_nxt = eng_rdata;
               if (rem_q == '0) state_nxt = GUARD;
               else             rem_nxt   = rem_q - 17'd1;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_nxt = ABORT;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
`endif
         end
         GUARD: begin
            if (cnt_q == CNT_W'(STOP_GUARD - 1)) state_nxt = DONE;
            else                                 cnt_nxt   = cnt_q + CNT_W'(1);
         end
         DONE: begin
            done_nxt  = gnt_q;
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
         ABORT: begin
`ifdef I2C_ARB_TIMEOUT_EN
            err_nxt   = gnt_q;
`endif
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         rr_q    <= '0;
         gnt_q   <= '0;
         stb_q   <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         start_q <= 1'b0;
         addr_q  <= '0;
         reg_q   <= '0;
         rd_q    <= 1'b0;
         rem_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         err_q   <= '0;
`endif
      end else begin
         state_q <= state_nxt;
         sel_q   <= sel_nxt;
         rr_q    <= rr_nxt;
         gnt_q   <= gnt_nxt;
         stb_q   <= stb_nxt;
         done_q  <= done_nxt;
         rdata_q <= rdata_nxt;
         start_q <= start_nxt;
         addr_q  <= addr_nxt;
         reg_q   <= reg_nxt;
         rd_q    <= rd_nxt;
         rem_q   <= rem_nxt;
         cnt_q   <= cnt_nxt;
         ready_q <= eng_ready;
`ifdef I2C_ARB_TIMEOUT_EN
         err_q   <= err_nxt;
`endif
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.byte_stb = stb_q;
   assign bus.rd_data  = rdata_q;
   assign bus.done     = done_q;
   assign eng_start    = start_q;
   assign eng_addr     = addr_q;
   assign eng_reg      = reg_q;
   assign eng_rd       = rd_q;
   assign eng_len      = rem_q;

`ifdef I2C_ARB_TIMEOUT_EN
   assign bus.err      = err_q;
   assign eng_reset    = reset | (state_q == ABORT);
`else
   assign bus.err      = '0;
   assign eng_reset    = reset;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized self-checking bench for i2c_bus_arbiter with a transaction-level
// reference model (round-robin pointer, pending set, per-byte expectations).
module tb_i2c_bus_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned SG = 64;

   logic        clock;
   logic        reset;
   logic        eng_start, eng_reset, eng_rd, eng_ready;
   logic [6:0]  eng_addr;
   logic [15:0] eng_reg;
   logic [16:0] eng_len;
   logic [7:0]  eng_wdata, eng_rdata;

   i2c_arb_if #(.N_REQ(N)) bus ();

   i2c_bus_arbiter #(.N_REQ(N), .STOP_GUARD(SG), .TIMEOUT(200000)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .eng_start (eng_start),
      .eng_reset (eng_reset),
      .eng_addr  (eng_addr),
      .eng_reg   (eng_reg),
      .eng_rd    (eng_rd),
      .eng_len   (eng_len),
      .eng_wdata (eng_wdata),
      .eng_ready (eng_ready),
      .eng_rdata (eng_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int          rr;
   bit          pend [N];
   logic [6:0]  d_addr [N];
   logic [15:0] d_reg [N];
   bit          d_rd [N];
   int          d_len [N];
   logic [7:0]  d_wd [N];
   logic [N-1:0] req_v;
   logic [7:0]  rq [$];
   int          rerq_budget;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      bus.req = req_v;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*7 +: 7]    = d_addr[i];
         bus.req_reg[i*16 +: 16]   = d_reg[i];
         bus.req_rd[i]             = d_rd[i];
         bus.req_len[i*17 +: 17]   = 17'(d_len[i]);
         bus.req_wdata[i*8 +: 8]   = d_wd[i];
      end
   endtask

   task automatic new_desc(input int k, input bit rd, input int len,
                           input logic [6:0] a, input logic [15:0] r);
      d_addr[k] = a;
      d_reg[k]  = r;
      d_rd[k]   = rd;
      d_len[k]  = len;
      d_wd[k]   = 8'($urandom);
      pend[k]   = 1'b1;
      req_v     = req_v | (N'(1) << k);
      drive();
   endtask

   function automatic int pick_next();
      for (int i = 0; i < N; i++) begin
         int c;
         c = (rr + i) % N;
         if (pend[c]) return c;
      end
      return -1;
   endfunction

   // Serve every pending requester; called at the negedge the requests were set.
   task automatic serve_all();
      int k, gap, hold;
      bit stray;
      logic [7:0] val;
      logic [N-1:0] oh;
      while (pick_next() >= 0) begin
         k  = pick_next();
         oh = N'(1) << k;
         stray = 1'b0;
         @(negedge clock);
         chk("gnt_early", 32'(bus.gnt), 32'(0));
         @(negedge clock);
         chk("gnt", 32'(bus.gnt), 32'(oh));
         chk("eng_addr", 32'(eng_addr), 32'(d_addr[k]));
         chk("eng_reg", 32'(eng_reg), 32'(d_reg[k]));
         chk("eng_rd", 32'(eng_rd), 32'(d_rd[k]));
         chk("eng_len0", 32'(eng_len), 32'(d_len[k]));
         chk("start_early", 32'(eng_start), 32'(0));
         @(negedge clock);
         chk("eng_start", 32'(eng_start), 32'(1));
         hold = 1;
         for (int b = 0; b <= d_len[k]; b++) begin
            gap = (b == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
            repeat (gap) begin
               @(negedge clock);
               if (bus.byte_stb != '0 || eng_start || bus.gnt != oh) stray = 1'b1;
            end
            chk("eng_len", 32'(eng_len), 32'(d_len[k] - b));
            if (!d_rd[k]) chk("eng_wdata", 32'(eng_wdata), 32'(d_wd[k]));
            val = (rq.size() > 0) ? rq.pop_front() : 8'($urandom);
            eng_rdata = val;
            eng_ready = 1'b1;
            hold = int'($urandom_range(1, 2));
            @(negedge clock);
            chk("byte_stb", 32'(bus.byte_stb), 32'(oh));
            if (d_rd[k]) chk("rd_data", 32'(bus.rd_data), 32'(val));
            if (b < d_len[k] && $urandom_range(0, 3) == 0) begin
               req_v = req_v & ~oh;
               drive();
            end
            if (hold == 2) begin
               eng_rdata = 8'($urandom);
               @(negedge clock);
               if (bus.byte_stb != '0) stray = 1'b1;
               if (d_rd[k]) chk("rd_hold", 32'(bus.rd_data), 32'(val));
            end
            eng_ready = 1'b0;
            eng_rdata = 8'($urandom);
            if (!d_rd[k]) begin
               d_wd[k] = 8'($urandom);
               drive();
            end
         end
         for (int c = hold; c <= SG + 1; c++) begin
            @(negedge clock);
            if (c <= SG && (bus.done != '0 || bus.byte_stb != '0 || bus.gnt != oh))
               stray = 1'b1;
         end
         chk("done", 32'(bus.done), 32'(oh));
         chk("gnt_clear", 32'(bus.gnt), 32'(0));
         chk("err", 32'(bus.err), 32'(0));
         chk("stray", 32'(stray), 32'(0));
         rr = (k + 1) % N;
         if (rerq_budget > 0 && $urandom_range(0, 2) == 0) begin
            rerq_budget--;
            new_desc(k, 1'($urandom), int'($urandom_range(0, 3)), 7'($urandom), 16'($urandom));
         end else begin
            pend[k] = 1'b0;
            req_v   = req_v & ~oh;
            drive();
         end
      end
   endtask

   initial begin
      int m;
      bit stray;
      reset     = 1'b1;
      eng_ready = 1'b0;
      eng_rdata = '0;
      req_v     = '0;
      rr        = 0;
      rerq_budget = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; d_addr[i] = '0; d_reg[i] = '0; d_rd[i] = 1'b0;
         d_len[i] = 0; d_wd[i] = '0;
      end
      drive();
      repeat (3) @(negedge clock);
      chk("rst_gnt", 32'(bus.gnt), 32'(0));
      chk("rst_stb", 32'(bus.byte_stb), 32'(0));
      chk("rst_done", 32'(bus.done), 32'(0));
      chk("rst_err", 32'(bus.err), 32'(0));
      chk("rst_rdata", 32'(bus.rd_data), 32'(0));
      chk("rst_start", 32'(eng_start), 32'(0));
      chk("rst_rd", 32'(eng_rd), 32'(0));
      chk("rst_addr", 32'(eng_addr), 32'(0));
      chk("rst_reg", 32'(eng_reg), 32'(0));
      chk("rst_len", 32'(eng_len), 32'(0));
      chk("rst_wdata", 32'(eng_wdata), 32'(0));
      chk("rst_eng_reset", 32'(eng_reset), 32'(1));
      reset = 1'b0;
      @(negedge clock);
      chk("eng_reset_rel", 32'(eng_reset), 32'(0));

      // All four requesting at once, single-byte writes: order 0,1,2,3
      for (int k = 0; k < N; k++) new_desc(k, 1'b0, 0, 7'($urandom), 16'($urandom));
      serve_all();

      // Single write from requester 0
      new_desc(0, 1'b0, 0, 7'h29, 16'h010F);
      d_wd[0] = 8'hA5;
      drive();
      serve_all();

      // Three-byte read from requester 2
      rq.push_back(8'h11); rq.push_back(8'h22); rq.push_back(8'h33);
      new_desc(2, 1'b1, 2, 7'h29, 16'h0020);
      serve_all();

      // Random request mixes with occasional immediate re-requests
      repeat (30) begin
         m = int'($urandom_range(1, (1 << N) - 1));
         rerq_budget = 2;
         for (int k = 0; k < N; k++)
            if (((m >> k) & 1) == 1)
               new_desc(k, 1'($urandom), int'($urandom_range(0, 3)), 7'($urandom), 16'($urandom));
         serve_all();
         repeat ($urandom_range(0, 3)) @(negedge clock);
         chk("idle_gnt", 32'(bus.gnt), 32'(0));
      end

      // Reset in the middle of a transfer
      new_desc(1, 1'b0, 3, 7'h52, 16'h1234);
      repeat (4) @(negedge clock);
      chk("mid_gnt", 32'(bus.gnt), 32'(2));
      reset = 1'b1;
      #1;
      chk("mid_eng_reset", 32'(eng_reset), 32'(1));
      @(negedge clock);
      chk("mid_gnt_clr", 32'(bus.gnt), 32'(0));
      chk("mid_done", 32'(bus.done), 32'(0));
      chk("mid_err", 32'(bus.err), 32'(0));
      chk("mid_start", 32'(eng_start), 32'(0));
      req_v = '0;
      pend[1] = 1'b0;
      drive();
      rr = 0;
      reset = 1'b0;
      #1;
      chk("mid_eng_reset_rel", 32'(eng_reset), 32'(0));
      stray = 1'b0;
      repeat (6) begin
         @(negedge clock);
         if (bus.gnt != '0 || bus.done != '0 || bus.err != '0 || bus.byte_stb != '0) stray = 1'b1;
      end
      chk("post_reset_quiet", 32'(stray), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C master engine among N_REQ requesters (ToF sensor drivers, configuration loader). Latches one requester's transaction descriptor, pulses the engine start, streams write bytes and read bytes through per-byte strobes, tracks the remaining byte count, and waits out the stop condition before granting the next requester. Sits between the ToF driver layer and the I2C engine that drives the SCL/SDA pads.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- STOP_GUARD, 64, clock cycles held after the final byte strobe so the engine completes STOP before the next start
- TIMEOUT, 200000, max clock cycles between byte strobes (used only with I2C_ARB_TIMEOUT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  N_REQ  per-requester request level, held until done/err
- req_addr  in  7*N_REQ  packed 7-bit slave addresses
- req_reg  in  16*N_REQ  packed 16-bit register addresses
- req_rd  in  N_REQ  1 = read, 0 = write
- req_len  in  17*N_REQ  packed byte count minus one
- req_wdata  in  8*N_REQ  packed write bytes, held stable until byte_stb
- gnt  out  N_REQ  one-hot grant, held for whole transaction
- byte_stb  out  N_REQ  one-cycle pulse per completed byte to granted requester
- rd_data  out  8  read byte, valid in byte_stb cycle, held until next
- done  out  N_REQ  one-cycle completion pulse
- err  out  N_REQ  one-cycle abort pulse
- eng_start, eng_reset  out  1 each  engine start pulse / engine reset
- eng_addr  out  7, eng_reg  out  16, eng_rd  out  1, eng_len  out  17, eng_wdata  out  8  engine descriptor
- eng_ready  in  1, eng_rdata  in  8  engine byte-ready level / read data

## Operation
- States: IDLE, LOAD, START, XFER, GUARD, DONE, ABORT (ABORT only with timeout).
- IDLE: if any req, pick first requester at or after rr_ptr (wrapping modulo N_REQ) → LOAD. rr_ptr updated to granted index + 1 (wrap) in LOAD.
- LOAD: assert gnt[k]; latch addr/reg/rd/len into descriptor registers; remaining <= req_len[k] → START.
- START: eng_start = 1 for exactly one cycle → XFER.
- XFER: byte boundary = rising edge of eng_ready (registered previous value). On edge: byte_stb[k] = 1; if reading, rd_data <= eng_rdata; if remaining == 0 → GUARD else remaining <= remaining − 1.
- eng_len always presents remaining; eng_wdata muxes req_wdata[k] combinationally from gnt.
- GUARD: count STOP_GUARD cycles → DONE. DONE: done[k] = 1, gnt cleared → IDLE.
- req[k] dropped mid-transaction: ignored; transaction runs to completion.
- Simultaneous requests: strict round-robin; a requester cannot win twice in a row while another is pending.
- req_len = 0: single byte, first edge goes straight to GUARD.
- remaining is 17-bit unsigned, never underflows (stops at 0).

## Timing
- Reset values: gnt = 0, byte_stb = 0, done = 0, err = 0, rd_data = 0, eng_start = 0, eng_rd = 0, eng_addr/reg/len/wdata = 0, rr_ptr = 0, state IDLE.
- eng_reset = reset OR (state == ABORT), combinational; arbiter reset mid-transaction resets engine in same cycle.
- Latency req → gnt: 2 cycles from IDLE (IDLE sample, LOAD registers gnt). gnt → eng_start: 1 cycle.
- byte_stb: 1 cycle after eng_ready rising edge (edge detector register).
- Last byte_stb → done: STOP_GUARD + 1 cycles. done → next gnt: 2 cycles minimum.

## Configuration
- I2C_ARB_TIMEOUT_EN defined: XFER watchdog counts cycles since START or last byte edge; reaching TIMEOUT → ABORT: eng_reset high 1 cycle, err[k] pulse, gnt cleared, no done → IDLE.
- Not defined: no watchdog, ABORT unreachable, err tied to 0, eng_reset = reset.

## Test plan
- Single write, requester 0, addr 0x29, reg 0x010F, len 0, byte 0xA5 → gnt[0] 2 cycles after req, eng_start one pulse, one byte_stb, done 65 cycles after byte_stb.
- Read, requester 2, len 2, engine model returns 0x11, 0x22, 0x33 → three byte_stb, rd_data sequence 0x11/0x22/0x33, eng_len 2→1→0, done[2].
- req = 4'b1111 held, each transaction len 0 → grants in order 0,1,2,3,0.
- Reset asserted mid-XFER → eng_reset high same cycle, gnt = 0 next cycle, no done/err.
- With I2C_ARB_TIMEOUT_EN, TIMEOUT = 100, engine never raises eng_ready → err[k] at cycle 100 after START, eng_reset 1-cycle pulse, next requester granted.
